instr_fetch_unit: RTL and testbench

//   Program counter + instruction register stage directly upstream of the

---
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Program counter and instruction register stage. Addresses the
//               program memory, registers the returned instruction and hands
//               it to the decoder over a valid/ready handshake. Handles
//               decoder redirects and stops fetching on a HALT opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int          ADDR_W       = 8,
    parameter int          INSTR_W      = 17,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 8'h00,
    parameter logic [4:0]  HALT_OPCODE  = 5'h1F
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  pm_addr,
    input  logic [INSTR_W-1:0] pm_data,
    output logic [INSTR_W-1:0] ir_out,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               dec_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    localparam logic [0:0] S_FETCH  = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_out_q, ir_out_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic [15:0]        fetch_count_q, fetch_count_d;

    logic w_accept;
    logic w_load;
    logic w_is_halt;

    // Handshake qualifiers shared by the FSM and the datapath
    always_comb begin
        w_accept  = ir_valid_q & dec_ready;
        w_load    = (state_q == S_FETCH) & (~ir_valid_q | dec_ready);
        w_is_halt = (pm_data[INSTR_W-1 -: 5] == HALT_OPCODE);
    end

    // State register: async reset returns the stage to fetching
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: redirect always resumes fetching, a loaded HALT word stops it
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = S_FETCH;
        end else if (w_load && w_is_halt) begin
            state_d = S_HALTED;
        end
    end

    // Outputs decoded from state
    always_comb begin
        halted = (state_q == S_HALTED);
    end

    // Datapath next values: redirect flushes, load captures, else hold
    // (a pending IR in HALTED is dropped once the decoder accepts it)
    always_comb begin
        pc_d          = pc_q;
        ir_out_d      = ir_out_q;
        ir_pc_d       = ir_pc_q;
        ir_valid_d    = ir_valid_q;
        fetch_count_d = fetch_count_q;
        if (redirect) begin
            pc_d       = redirect_addr;
            ir_valid_d = 1'b0;
        end else if (w_load) begin
            ir_out_d      = pm_data;
            ir_pc_d       = pc_q;
            ir_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + 16'd1;
            pc_d          = w_is_halt ? pc_q : pc_q + ADDR_W'(1);
        end else if (w_accept) begin
            ir_valid_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_VECTOR;
            ir_out_q      <= '0;
            ir_pc_q       <= '0;
            ir_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            ir_out_q      <= ir_out_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pm_addr     = pc_q;
    assign ir_out      = ir_out_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = ir_valid_q;
    assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit with a
//               combinational program memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic [7:0]  pm_addr;
    logic [16:0] pm_data;
    logic [16:0] ir_out;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        dec_ready;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic        halted;
    logic [15:0] fetch_count;

    logic [16:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pm_addr       (pm_addr),
        .pm_data       (pm_data),
        .ir_out        (ir_out),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .dec_ready     (dec_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    assign pm_data = mem[pm_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 17'h00100 + 17'(i);
        reset = 1'b1; dec_ready = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
        step();
        step();
        reset = 1'b0;

        // 1: reset values
        check_eq("rst_pm_addr", 32'(pm_addr), 32'h00);
        check_eq("rst_valid", 32'(ir_valid), 32'h0);
        check_eq("rst_halted", 32'(halted), 32'h0);
        check_eq("rst_count", 32'(fetch_count), 32'h0);

        // 2: full-throughput streaming of addresses 0..7
        dec_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check_eq("stream_ir_pc", 32'(ir_pc), 32'(k));
            check_eq("stream_ir_out", 32'(ir_out), 32'h00100 + 32'(k));
            check_eq("stream_valid", 32'(ir_valid), 32'h1);
        end
        check_eq("stream_count", 32'(fetch_count), 32'd8);

        // 3: stall with ir_pc=2
        do_reset();
        for (int k = 0; k < 3; k++) step();
        check_eq("pre_stall_ir_pc", 32'(ir_pc), 32'h2);
        dec_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("stall_ir_pc", 32'(ir_pc), 32'h2);
            check_eq("stall_ir_out", 32'(ir_out), 32'h00102);
            check_eq("stall_pm_addr", 32'(pm_addr), 32'h3);
            check_eq("stall_valid", 32'(ir_valid), 32'h1);
            check_eq("stall_count", 32'(fetch_count), 32'd3);
        end
        dec_ready = 1'b1;
        step();
        check_eq("unstall_ir_pc", 32'(ir_pc), 32'h3);
        step();
        step();
        check_eq("pre_redir_ir_pc", 32'(ir_pc), 32'h5);

        // 4: redirect to 0x40 while ir_pc=5 valid and accepted
        redirect = 1'b1; redirect_addr = 8'h40;
        step();
        check_eq("redir_valid", 32'(ir_valid), 32'h0);
        check_eq("redir_pm_addr", 32'(pm_addr), 32'h40);
        check_eq("redir_count", 32'(fetch_count), 32'd6);
        redirect = 1'b0; redirect_addr = 8'h77;
        step();
        check_eq("post_redir_ir_pc", 32'(ir_pc), 32'h40);
        check_eq("post_redir_valid", 32'(ir_valid), 32'h1);
        check_eq("post_redir_ir_out", 32'(ir_out), 32'h00140);
        check_eq("post_redir_pm_addr", 32'(pm_addr), 32'h41);

        // 5: PC wrap from 0xFF to 0x00
        redirect = 1'b1; redirect_addr = 8'hFE;
        step();
        check_eq("wrap_redir_pm_addr", 32'(pm_addr), 32'hFE);
        redirect = 1'b0; redirect_addr = 8'h33;
        step();
        check_eq("wrap_ir_pc_fe", 32'(ir_pc), 32'hFE);
        step();
        check_eq("wrap_ir_pc_ff", 32'(ir_pc), 32'hFF);
        step();
        check_eq("wrap_ir_pc_00", 32'(ir_pc), 32'h00);
        check_eq("wrap_ir_out_00", 32'(ir_out), 32'h00100);
        check_eq("wrap_pm_addr", 32'(pm_addr), 32'h01);
        check_eq("wrap_count", 32'(fetch_count), 32'd10);

        // 6: HALT at address 3
        mem[3] = {5'h1F, 12'h0AB};
        do_reset();
        for (int k = 0; k < 4; k++) step();
        check_eq("halt_ir_pc", 32'(ir_pc), 32'h3);
        check_eq("halt_ir_out", 32'(ir_out), 32'h1F0AB);
        check_eq("halt_valid", 32'(ir_valid), 32'h1);
        check_eq("halt_flag", 32'(halted), 32'h1);
        check_eq("halt_pm_addr", 32'(pm_addr), 32'h3);
        dec_ready = 1'b0;
        step();
        step();
        check_eq("halt_hold_valid", 32'(ir_valid), 32'h1);
        check_eq("halt_hold_ir_out", 32'(ir_out), 32'h1F0AB);
        check_eq("halt_hold_count", 32'(fetch_count), 32'd4);
        dec_ready = 1'b1;
        step();
        check_eq("halt_accept_valid", 32'(ir_valid), 32'h0);
        check_eq("halt_accept_flag", 32'(halted), 32'h1);
        step();
        check_eq("halt_idle_valid", 32'(ir_valid), 32'h0);
        check_eq("halt_idle_pm_addr", 32'(pm_addr), 32'h3);
        check_eq("halt_idle_count", 32'(fetch_count), 32'd4);
        redirect = 1'b1; redirect_addr = 8'h10;
        step();
        check_eq("resume_halted", 32'(halted), 32'h0);
        check_eq("resume_pm_addr", 32'(pm_addr), 32'h10);
        redirect = 1'b0;
        step();
        check_eq("resume_ir_pc", 32'(ir_pc), 32'h10);
        check_eq("resume_valid", 32'(ir_valid), 32'h1);
        check_eq("resume_count", 32'(fetch_count), 32'd5);

        // Asynchronous reset mid-run, checked before the next clock edge
        reset = 1'b1;
        #1;
        check_eq("async_rst_pm_addr", 32'(pm_addr), 32'h00);
        check_eq("async_rst_valid", 32'(ir_valid), 32'h0);
        check_eq("async_rst_ir_out", 32'(ir_out), 32'h0);
        check_eq("async_rst_ir_pc", 32'(ir_pc), 32'h0);
        check_eq("async_rst_halted", 32'(halted), 32'h0);
        check_eq("async_rst_count", 32'(fetch_count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
